// File: rtl/alu_pkg.sv
// Opcode constants shared with the ALU control unit, plus the execute-stage state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: low WIDTH bits of unsigned a*b after WIDTH steps.
// done pulses combinationally on the final step; product already includes that step.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             running_q, running_d;
    logic [WIDTH-1:0] acc_step;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done     = running_q && (count_q == LAST);
    assign product  = acc_step;

    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        running_d = running_q;
        if (start) begin
            mcand_d   = a;
            mplier_d  = b;
            acc_d     = '0;
            count_d   = '0;
            running_d = 1'b1;
        end else if (running_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
            if (done) begin
                running_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            running_q <= running_d;
        end
    end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with registered result/flags and valid/ready handshake.
// Single-cycle ops finish at the accept edge; mul hands off to seq_multiplier for WIDTH cycles.
module ex_alu_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUctrlop,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);
    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] sum, diff, alu_res, mul_product;
    logic             add_ovf, sub_ovf, alu_ovf;
    logic             accept, mul_start, mul_done;

    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (ALUctrlop == ALU_MUL);
    assign busy      = (state_q == MUL);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;

    // Sub overflow treats B as inverted: signs differ and the result sign leaves A's.
    assign sum     = op_a + op_b;
    assign diff    = op_a - op_b;
    assign add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1]  != op_a[WIDTH-1]);
    assign sub_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUctrlop)
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_ADD: begin alu_res = sum;  alu_ovf = add_ovf; end
            ALU_SUB: begin alu_res = diff; alu_ovf = sub_ovf; end
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
            ALU_NOR: alu_res = ~(op_a | op_b);
            default: alu_res = '0;
        endcase
    end

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (mul_start) begin
                    state_d = MUL;
                end else if (accept) begin
                    result_d    = alu_res;
                    zero_d      = (alu_res == '0);
                    overflow_d  = alu_ovf;
                    out_valid_d = 1'b1;
                end
            end
            MUL: begin
                // Output register was freed at accept, so completion cannot clobber a result.
                if (mul_done) begin
                    result_d    = mul_product;
                    zero_d      = (mul_product == '0);
                    overflow_d  = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
Execute-stage ALU that consumes the 4-bit ALUctrlop produced by the ALU control unit together with two operands from the ID/EX path. It produces a registered result with zero and overflow flags under a valid/ready handshake. Single-cycle ops (and, or, add, sub, slt, nor) complete in one cycle. An added unsigned multiply op runs as an iterative shift-add sequence over WIDTH cycles, with input backpressure while it is busy.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands and ALUctrlop valid this cycle
in_ready  output  1  stage can accept an operation this cycle
ALUctrlop  input  4  operation select from ALU control unit
op_a  input  WIDTH  operand A (rs value)
op_b  input  WIDTH  operand B (rt value or sign-extended immediate)
out_valid  output  1  result/flags valid
out_ready  input  1  downstream (EX/MEM) accepts result this cycle
result  output  WIDTH  registered ALU result
zero  output  1  registered (result == 0)
overflow  output  1  registered signed overflow (add/sub only, else 0)
busy  output  1  multiply in progress

Behaviour:
- Reset, on a clock edge with reset=1, overrides everything: state=IDLE, out_valid=0, result=0, zero=0, overflow=0, multiply counter/accumulators=0. Reset mid-multiply aborts it and produces no result.
- Opcodes: 0000 and; 0001 or; 0010 add; 0110 sub; 0111 slt; 1100 nor; 1000 mul (low WIDTH bits of unsigned a*b). Any other code gives result=0, zero=1, overflow=0, latency 1.
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational from state and out_ready only. No dependence on in_valid.
- States:
  - IDLE: on a non-mul transfer in, load result/zero/overflow and set out_valid=1 at the same edge (latency 1). On a mul transfer in, latch operands, set count=0, go to MUL, out_valid=0 unless an old result is still held.
  - MUL: each cycle, if the multiplier LSB is 1, add the shifted multiplicand into the accumulator; then shift the multiplicand left and the multiplier right; count++. At the edge where count==WIDTH-1: write result=accumulator (final step included), zero=(result==0), overflow=0, out_valid=1, go to IDLE. out_valid rises exactly WIDTH edges after the accept edge.
- A mul is only accepted when the output register is free or draining, so the MUL to IDLE completion never overwrites an unconsumed result.
- Hold rule: while out_valid && !out_ready, result/zero/overflow/out_valid hold stable.
- Output drain without a new transfer in clears out_valid at that edge. Simultaneous drain and non-mul accept keeps out_valid=1 with the new data, giving 1 op/cycle throughput.
- add/sub: WIDTH-bit wrap. overflow = operand signs (B inverted for sub) equal and result sign differs.
- slt: signed compare; result = {0..., (a-b)[MSB] XOR ovf}.
- busy = (state==MUL). Operand inputs are ignored while busy.

Decomposition:
- Shared package alu_pkg: 4-bit opcode localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_MUL) and the state encoding (IDLE, MUL). The ALU control unit should migrate to these constants.
- One sub-module: seq_multiplier (start, a, b, done, product; WIDTH-cycle shift-add). The FSM and handshake stay in ex_alu_stage.

Test Plan:
- Drive add with a=5, b=3, out_ready=1. Expect result=8, zero=0, overflow=0, out_valid high one cycle after accept.
- Drive sub with a=7, b=7. Expect result=0, zero=1. Then add with a=0x7FFFFFFF, b=1: expect result=0x80000000, overflow=1.
- Drive slt with a=0xFFFFFFFF (-1), b=1: expect result=1. Drive slt with a=0x80000000, b=0x7FFFFFFF: expect result=1 (overflow-corrected).
- Drive mul with a=6, b=7. Expect busy=1 and in_ready=0 for 32 cycles, out_valid exactly 32 edges after accept, result=42. Then a=0xFFFFFFFF, b=2: expect result=0xFFFFFFFE.
- Back-to-back non-mul ops with out_ready=1 every cycle: one result per cycle, in order. Then hold out_ready=0 for 3 cycles: result stable and in_ready=0 throughout.
- Assert reset at MUL cycle 10: next edge state=IDLE, out_valid=0, busy=0, result=0. A subsequent add of 1+1 returns 2.
